// File: rtl/div_sequencer_pkg.sv
// Shared op codes, FSM state encodings and result-valid levels for the RV32M divide sequencer.
package div_sequencer_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] EXE_DIV_OP  = 2'b00;
  localparam logic [1:0] EXE_DIVU_OP = 2'b01;
  localparam logic [1:0] EXE_REM_OP  = 2'b10;
  localparam logic [1:0] EXE_REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_sequencer_div_step.sv
// One restoring shift-subtract iteration: shift {rem, quot} left, subtract divisor when it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quot,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quot_next
);

  // The shifted partial remainder can reach W+1 bits before the subtract.
  logic [W:0] trial;
  logic [W:0] diff;

  assign trial = {rem, quot[W-1]};
  assign diff  = trial - {1'b0, divisor};

  always_comb begin
    rem_next  = trial[W-1:0];
    quot_next = {quot[W-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_next  = diff[W-1:0];
      quot_next = {quot[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-cycle restoring divider with stall request.
// Optional build macro DIV_EARLY_OUT_EN skips the loop when |divisor| > |dividend|.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             start_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             stallreq_o
);

  div_state_e       state, state_nxt;
  logic [1:0]       op_q;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic [WIDTH-1:0] rem_step, quot_step;
  logic             neg_quot, neg_rem, fix_en;

  logic             is_signed, sgn1, sgn2, div_zero, early;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] quot_fix, rem_fix, res_fix;

  assign is_signed = ~op_i[0];
  assign sgn1      = is_signed & opdata1_i[WIDTH-1];
  assign sgn2      = is_signed & opdata2_i[WIDTH-1];
  assign mag1      = magnitude(opdata1_i, sgn1);
  assign mag2      = magnitude(opdata2_i, sgn2);
  assign div_zero  = (opdata2_i == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = ~div_zero & (mag2 > mag1);
`else
  assign early = 1'b0;
`endif

  div_step #(.W(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_step),
    .quot_next (quot_step)
  );

  // Divide-by-zero results bypass the sign fix-up via fix_en.
  assign quot_fix = (fix_en & neg_quot) ? -quot : quot;
  assign rem_fix  = (fix_en & neg_rem)  ? -rem  : rem;
  assign res_fix  = op_q[1] ? rem_fix : quot_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DivFree;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (annul_i) begin
      state_nxt = DivFree;
    end else begin
      case (state)
        DivFree:   if (start_i) state_nxt = div_zero ? DivByZero : (early ? DivEnd : DivOn);
        DivOn:     if (cnt == 5'd31) state_nxt = DivEnd;
        DivByZero: state_nxt = DivEnd;
        DivEnd:    if (!start_i) state_nxt = DivFree;
        default:   state_nxt = DivFree;
      endcase
    end
  end

  always_comb begin
    stallreq_o = start_i & ~annul_i & (state != DivEnd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      fix_en   <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else if (annul_i) begin
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      case (state)
        DivFree: begin
          if (start_i) begin
            op_q     <= op_i;
            divisor  <= mag2;
            neg_quot <= sgn1 ^ sgn2;
            neg_rem  <= sgn1;
            cnt      <= '0;
            if (div_zero) begin
              rem    <= opdata1_i;
              quot   <= '1;
              fix_en <= 1'b0;
            end else if (early) begin
              rem    <= mag1;
              quot   <= '0;
              fix_en <= 1'b1;
            end else begin
              rem    <= '0;
              quot   <= mag1;
              fix_en <= 1'b1;
            end
          end
        end
        DivOn: begin
          rem  <= rem_step;
          quot <= quot_step;
          cnt  <= cnt + 5'd1;
        end
        DivEnd: begin
          if (start_i) begin
            ready_o  <= DivResultReady;
            result_o <= res_fix;
          end else begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
